// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the generic pipeline stage
package pipe_pkg;

  // Stage occupancy as seen on the occ port
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } pipe_occ_t;

  // Default width of the statistics counters
  localparam int PIPE_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter, cleared only by reset
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE_VAL = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count qualifying cycles and stick at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE_VAL;
    end
  end

endmodule

// File: rtl/ctrl_pipe_stage_skid.sv
// rtl/ctrl_pipe_stage_skid.sv - generic skid-buffered pipeline stage register (stats: CTRL_PIPE_STAT_EN)
module ctrl_pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W      = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output pipe_occ_t        occ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic             in_fire;
  logic             out_fire;

  // in_ready comes straight from the skid flop, so upstream never sees out_ready combinationally
  assign in_ready  = ~skid_v;
  assign in_fire   = in_valid & ~skid_v;
  assign out_valid = main_v;
  assign out_fire  = main_v & out_ready;
  assign out_data  = main_v ? main_d : BUBBLE_VAL;

  // Occupancy decode; skid is only ever filled behind a valid main entry
  always_comb begin
    occ = OCC_EMPTY;
    if (skid_v) begin
      occ = OCC_FULL;
    end else if (main_v) begin
      occ = OCC_ONE;
    end
  end

  // Valid bits: flush wins over any handshake in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (out_fire) begin
        skid_v <= 1'b0;
      end
    end else if (main_v) begin
      if (out_fire && !in_fire) begin
        main_v <= 1'b0;
      end else if (!out_fire && in_fire) begin
        skid_v <= 1'b1;
      end
    end else if (in_fire) begin
      main_v <= 1'b1;
    end
  end

  // Data registers load only on a real transfer, never on idle or flush cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_d <= BUBBLE_VAL;
      skid_d <= BUBBLE_VAL;
    end else if (!flush) begin
      if (skid_v) begin
        if (out_fire) begin
          main_d <= skid_d;
        end
      end else if (in_fire) begin
        if (!main_v || out_fire) begin
          main_d <= in_data;
        end else begin
          skid_d <= in_data;
        end
      end
    end
  end

`ifdef CTRL_PIPE_STAT_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (main_v & ~out_ready),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~main_v),
    .cnt (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_stage_skid.sv
// tb/tb_ctrl_pipe_stage_skid.sv - scoreboard bench for ctrl_pipe_stage_skid
module tb_ctrl_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int          W   = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] BUB = 32'hDEAD_0000;
`ifdef CTRL_PIPE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  pipe_occ_t     occ;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  ctrl_pipe_stage_skid #(
    .WIDTH      (W),
    .BUBBLE_VAL (BUB),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occ        (occ),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one input beat; record it as expected output if the stage will take it
  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    if (v && in_ready && !flush) exp_q.push_back(d);
  endtask

  // Monitor: compare every downstream transfer against the scoreboard, bubbles against BUB
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h expected=none", out_data);
        end else begin
          chk("out_data_order", out_data, exp_q.pop_front());
        end
      end else if (!out_valid) begin
        chk("bubble_val", out_data, BUB);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, BUB);
    chk("rst_occ", 32'(occ), 32'(OCC_EMPTY));
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 0);
    #10 rst = 1'b0;

    // Streaming 1..10 at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i > 1) begin
        chk("stream_occ", 32'(occ), 32'(OCC_ONE));
        chk("stream_latency", out_data, 32'(i - 1));
      end
      chk("stream_in_ready", 32'(in_ready), 1);
      drive(1'b1, 32'(i));
    end
    tick();
    chk("stream_last", out_data, 32'd10);
    drive(1'b0, 32'd0);
    tick();
    chk("stream_drain_occ", 32'(occ), 32'(OCC_EMPTY));

    // Backpressure: A then B into a stalled stage
    out_ready = 1'b0;
    tick();
    drive(1'b1, 32'hA);
    tick();
    chk("bp_occ_one", 32'(occ), 32'(OCC_ONE));
    chk("bp_out_a", out_data, 32'hA);
    drive(1'b1, 32'hB);
    tick();
    drive(1'b0, 32'd0);
    chk("bp_occ_full", 32'(occ), 32'(OCC_FULL));
    chk("bp_in_ready_low", 32'(in_ready), 0);
    repeat (3) tick();
    chk("bp_hold_occ", 32'(occ), 32'(OCC_FULL));
    chk("bp_hold_data", out_data, 32'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_in_ready_back", 32'(in_ready), 1);
    chk("bp_occ_after", 32'(occ), 32'(OCC_ONE));
    chk("bp_out_b", out_data, 32'hB);
    tick();
    chk("bp_drain_occ", 32'(occ), 32'(OCC_EMPTY));

    // Flush while FULL with a pending input 0xC
    out_ready = 1'b0;
    tick();
    drive(1'b1, 32'hD);
    tick();
    drive(1'b1, 32'hE);
    tick();
    chk("fl_full_occ", 32'(occ), 32'(OCC_FULL));
    flush = 1'b1;
    drive(1'b1, 32'hC);
    exp_q.delete();
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0);
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_out_data", out_data, BUB);
    chk("fl_occ", 32'(occ), 32'(OCC_EMPTY));
    chk("fl_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Flush while ONE with a ready input: the input beat is discarded
    out_ready = 1'b0;
    tick();
    drive(1'b1, 32'h11);
    tick();
    chk("fl1_occ_one", 32'(occ), 32'(OCC_ONE));
    flush = 1'b1;
    drive(1'b1, 32'hF);
    exp_q.delete();
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0);
    chk("fl1_occ", 32'(occ), 32'(OCC_EMPTY));
    chk("fl1_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (2) tick();

    // Flush while EMPTY has no effect, next beat flows normally
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl0_occ", 32'(occ), 32'(OCC_EMPTY));
    chk("fl0_in_ready", 32'(in_ready), 1);
    drive(1'b1, 32'h22);
    tick();
    drive(1'b0, 32'd0);
    chk("fl0_next", out_data, 32'h22);
    tick();

    // Asynchronous reset mid-cycle while ONE
    out_ready = 1'b0;
    tick();
    drive(1'b1, 32'h7);
    tick();
    drive(1'b0, 32'd0);
    chk("ar_occ_one", 32'(occ), 32'(OCC_ONE));
    chk("ar_valid_before", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 0);
    chk("ar_out_data", out_data, BUB);
    chk("ar_occ", 32'(occ), 32'(OCC_EMPTY));
    chk("ar_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    out_ready = 1'b1;
    drive(1'b1, 32'h5);
    tick();
    drive(1'b0, 32'd0);
    chk("ar_first_out", out_data, 32'h5);
    tick();

    // Statistics counters: exact counts from a fresh reset
    @(posedge clk);
    #3 rst = 1'b1;
    #2;
    chk("st_rst_stall", 32'(stall_cnt), 0);
    exp_q.delete();
    #3 rst = 1'b0;
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h9);
    tick();
    drive(1'b0, 32'd0);
    chk("st_bubble_2", 32'(bubble_cnt), STAT ? 32'd2 : 32'd0);
    repeat (3) tick();
    chk("st_stall_3", 32'(stall_cnt), STAT ? 32'd3 : 32'd0);
    repeat (20) tick();
    chk("st_stall_sat", 32'(stall_cnt), STAT ? 32'd15 : 32'd0);
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    chk("st_stall_after_flush", 32'(stall_cnt), STAT ? 32'd15 : 32'd0);
    repeat (20) tick();
    chk("st_bubble_sat", 32'(bubble_cnt), STAT ? 32'd15 : 32'd0);
    chk("st_stall_kept", 32'(stall_cnt), STAT ? 32'd15 : 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_stage_skid.md
Name: ctrl_pipe_stage_skid

Overview:
- Parametrised pipeline stage register for control/data bundles between any two pipeline stages (DE->EX, EX->MEM, ...).
- Replaces fixed, hand-listed stage registers with one generic block:
  - valid/ready handshake;
  - 2-entry skid buffer, so upstream ready is registered;
  - synchronous flush;
  - bubble value driven whenever the stage is empty.
- Full throughput: 1 bundle/cycle; 1-cycle latency.

Parameters:
- WIDTH, 32, bit width of the packed control/data bundle.
- BUBBLE_VAL, '0, value driven on out_data when out_valid=0 (NOP bundle).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear: kill all held bundles.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept a bundle; registered.
- in_data  in  WIDTH  upstream bundle.
- out_valid  out  1  downstream bundle valid.
- out_ready  in  1  downstream accepts the bundle (0 = stall).
- out_data  out  WIDTH  held bundle, or BUBBLE_VAL when empty.
- occ  out  2  occupancy: pipe_occ_t (EMPTY/ONE/FULL).
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready.
- bubble_cnt  out  CNT_W  cycles with ~out_valid.

Behaviour:
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - out_valid = main_v.
  - out_data = main_v ? main_d : BUBBLE_VAL.
  - in_ready = ~skid_v, taken from the flop; no combinational path from out_ready.
- State machine (occ):
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE, out_fire & in_fire -> ONE, main <= in.
  - ONE, out_fire & ~in_fire -> EMPTY.
  - ONE, ~out_fire & in_fire -> FULL, skid <= in.
  - ONE, neither -> hold.
  - FULL: out_fire -> ONE, main <= skid, skid_v <= 0. in_ready is 0, so no input is taken.
  - FULL, ~out_fire -> hold.
- Ordering: strict FIFO order. No bundle is dropped or duplicated except on flush.
- Latency: a bundle accepted at cycle t appears on out_data at t+1 if main is free.
- Flush:
  - Highest synchronous priority. Next cycle: main_v=0, skid_v=0, occ=EMPTY, in_ready=1.
  - Any in_fire or out_fire in the flush cycle is ignored for state purposes. The input bundle is discarded.
  - flush while EMPTY: no effect.
- Reset (async, any time, including mid-transfer):
  - main_v=0, skid_v=0, main_d=skid_d=BUBBLE_VAL, occ=EMPTY, in_ready=1.
  - out_valid=0, out_data=BUBBLE_VAL, counters=0.
- in_data is captured only on in_fire. Data flops do not toggle otherwise.
- in_valid with in_ready=0: the bundle must be held by upstream; no capture.

Optional Feature:
- Macro: CTRL_PIPE_STAT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - bubble_cnt increments each cycle with ~out_valid.
  - Both saturate at 2^CNT_W-1.
  - Cleared by rst only; flush does not clear them.
- Undefined: counter logic is not built; stall_cnt and bubble_cnt are tied to 0. Port list is unchanged.

Decomposition:
- pipe_pkg:
  - typedef enum logic [1:0] pipe_occ_t {OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2}.
  - Default CNT_W constant.
- Sub-module pipe_sat_counter (CNT_W; clk, rst, inc, cnt): instantiated twice under CTRL_PIPE_STAT_EN.

Test Plan:
- Streaming: in_valid=1 with data 1,2,3,... and out_ready=1 for 10 cycles -> out_data 1,2,3,... with 1-cycle lag; in_ready constant 1; occ=ONE.
- Backpressure: send 0xA then 0xB with out_ready=0 -> occ=FULL, in_ready=0. Then out_ready=1 -> out 0xA, then 0xB; no loss; in_ready returns to 1 one cycle after the first out_fire.
- Flush while FULL with in_valid=1 and data 0xC -> next cycle out_valid=0, out_data=BUBBLE_VAL, occ=EMPTY, in_ready=1; 0xC never appears on the output.
- Async rst asserted mid-cycle while ONE -> out_valid=0 and out_data=BUBBLE_VAL immediately, before the next clk edge. After release, first input 0x5 -> out 0x5 one cycle later.
- With CTRL_PIPE_STAT_EN and CNT_W=4: hold a stall for 20 cycles -> stall_cnt saturates at 15; a flush does not clear it. Without the macro, stall_cnt and bubble_cnt stay 0.
